// File: rtl/dns_query_parser.sv
// dns_query_parser: accepts one DNS message per handshake on a wide bus.
// It decodes the 12-byte header, then walks the first question's QNAME one
// byte per cycle and extracts QTYPE/QCLASS. Results and an error code are
// presented on a valid/ready output port.
//
// Parameters:
//   PKT_WIDTH      payload bus width in bits (multiple of 8, >= 136)
//   MAX_NAME_BYTES QNAME buffer capacity in wire-format bytes (2..255)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pkt, pkt_valid, pkt_ready   payload input (byte 0 at the top bits)
//   out_valid, out_ready        result handshake
//   out_id, out_flags           header ID and flags word, verbatim
//   out_qdcount .. out_arcount  header counts, verbatim
//   out_qname, out_qname_len    left-justified wire-format QNAME and its length
//   out_qtype, out_qclass       question type/class (0 on any error)
//   out_err                     0 OK, 1 NO_QUESTION, 2 BAD_LABEL, 3 COMPRESS,
//                               4 NAME_LONG, 5 TRUNC
//
// Optional feature (macro DNS_QUERY_PARSER_STATS_EN):
//   stat_pkts, stat_errs        32-bit wrapping counters of output handshakes
//                               and of those carrying a nonzero out_err
module dns_query_parser #(
    parameter int unsigned PKT_WIDTH      = 4096,
    parameter int unsigned MAX_NAME_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PKT_WIDTH-1:0]          pkt,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_id,
    output logic [15:0]                   out_flags,
    output logic [15:0]                   out_qdcount,
    output logic [15:0]                   out_ancount,
    output logic [15:0]                   out_nscount,
    output logic [15:0]                   out_arcount,
    output logic [8*MAX_NAME_BYTES-1:0]   out_qname,
    output logic [7:0]                    out_qname_len,
    output logic [15:0]                   out_qtype,
    output logic [15:0]                   out_qclass,
    output logic [2:0]                    out_err
`ifdef DNS_QUERY_PARSER_STATS_EN
    ,
    output logic [31:0]                   stat_pkts,
    output logic [31:0]                   stat_errs
`endif
);

    localparam int unsigned PKT_BYTES = PKT_WIDTH / 8;
    localparam int unsigned CNT_W     = $clog2(PKT_BYTES + 5);
    localparam int unsigned QN_W      = 8 * MAX_NAME_BYTES;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_NO_QUEST = 3'd1;
    localparam logic [2:0] ERR_BAD_LAB  = 3'd2;
    localparam logic [2:0] ERR_COMPRESS = 3'd3;
    localparam logic [2:0] ERR_NAME_LNG = 3'd4;
    localparam logic [2:0] ERR_TRUNC    = 3'd5;

    typedef enum logic [2:0] {IDLE, HDR, NAME, QTAIL, DONE} state_t;

    state_t               state;
    logic [PKT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           lab_rem;
    logic [7:0]           top_byte;

    // Byte currently at the head of the payload shift register
    assign top_byte = shreg[PKT_WIDTH-1 -: 8];

    // Parser FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            lab_rem       <= '0;
            pkt_ready     <= 1'b0;
            out_valid     <= 1'b0;
            out_id        <= '0;
            out_flags     <= '0;
            out_qdcount   <= '0;
            out_ancount   <= '0;
            out_nscount   <= '0;
            out_arcount   <= '0;
            out_qname     <= '0;
            out_qname_len <= '0;
            out_qtype     <= '0;
            out_qclass    <= '0;
            out_err       <= ERR_OK;
`ifdef DNS_QUERY_PARSER_STATS_EN
            stat_pkts     <= '0;
            stat_errs     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_valid && pkt_ready) begin
                        shreg         <= pkt;
                        cnt           <= '0;
                        lab_rem       <= '0;
                        out_qname     <= '0;
                        out_qname_len <= '0;
                        out_qtype     <= '0;
                        out_qclass    <= '0;
                        out_err       <= ERR_OK;
                        pkt_ready     <= 1'b0;
                        state         <= HDR;
                    end else begin
                        pkt_ready <= 1'b1;
                    end
                end

                HDR: begin
                    out_id      <= shreg[PKT_WIDTH-1  -: 16];
                    out_flags   <= shreg[PKT_WIDTH-17 -: 16];
                    out_qdcount <= shreg[PKT_WIDTH-33 -: 16];
                    out_ancount <= shreg[PKT_WIDTH-49 -: 16];
                    out_nscount <= shreg[PKT_WIDTH-65 -: 16];
                    out_arcount <= shreg[PKT_WIDTH-81 -: 16];
                    shreg       <= shreg << 96;
                    cnt         <= CNT_W'(12);
                    if (shreg[PKT_WIDTH-33 -: 16] == 16'd0) begin
                        out_err   <= ERR_NO_QUEST;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= NAME;
                    end
                end

                NAME: begin
                    // Truncation outranks buffer overflow; neither stores the byte
                    if (cnt == CNT_W'(PKT_BYTES)) begin
                        out_err   <= ERR_TRUNC;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (out_qname_len == 8'(MAX_NAME_BYTES)) begin
                        out_err   <= ERR_NAME_LNG;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (lab_rem == 8'd0 && top_byte[7:6] == 2'b11) begin
                        out_err   <= ERR_COMPRESS;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (lab_rem == 8'd0 && top_byte[7:6] != 2'b00) begin
                        out_err   <= ERR_BAD_LAB;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        for (int i = 0; i < int'(MAX_NAME_BYTES); i++) begin
                            if (out_qname_len == 8'(i))
                                out_qname[int'(QN_W)-1-8*i -: 8] <= top_byte;
                        end
                        out_qname_len <= out_qname_len + 8'd1;
                        shreg         <= shreg << 8;
                        cnt           <= cnt + CNT_W'(1);
                        if (lab_rem != 8'd0)
                            lab_rem <= lab_rem - 8'd1;
                        else if (top_byte == 8'd0)
                            state <= QTAIL;
                        else
                            lab_rem <= top_byte;
                    end
                end

                QTAIL: begin
                    if (cnt + CNT_W'(4) > CNT_W'(PKT_BYTES)) begin
                        out_err <= ERR_TRUNC;
                    end else begin
                        out_qtype  <= shreg[PKT_WIDTH-1  -: 16];
                        out_qclass <= shreg[PKT_WIDTH-17 -: 16];
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pkt_ready <= 1'b1;
                        state     <= IDLE;
`ifdef DNS_QUERY_PARSER_STATS_EN
                        stat_pkts <= stat_pkts + 32'd1;
                        if (out_err != ERR_OK)
                            stat_errs <= stat_errs + 32'd1;
`endif
                    end
                end

                default: begin
                    pkt_ready <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
